// File: rtl/exec_ctrl_mem_unit_pkg.sv
// Shared encodings for the execute/memory slice: opcodes, function codes and
// the control-field values produced by the decoder.
package exec_ctrl_mem_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_OR    = 3'b010,
      ALU_AND   = 3'b011,
      ALU_SLL   = 3'b100,
      ALU_PASSB = 3'b101
   } alu_op_e;

   typedef enum logic [2:0] {
      CMP_EQ = 3'b000,
      CMP_NE = 3'b001,
      CMP_LT = 3'b010
   } cmp_op_e;

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_RS     = 2'b11;

   localparam logic [1:0] DST_RD     = 2'b00;
   localparam logic [1:0] DST_RT     = 2'b01;
   localparam logic [1:0] DST_RA     = 2'b10;

   localparam logic [1:0] EXT_ZERO   = 2'b00;
   localparam logic [1:0] EXT_SIGN   = 2'b01;
   localparam logic [1:0] EXT_LUI    = 2'b10;

   localparam logic [2:0] D2R_ALU    = 3'b000;
   localparam logic [2:0] D2R_MEM    = 3'b001;
   localparam logic [2:0] D2R_PC4    = 3'b010;
   localparam logic [2:0] D2R_CMP    = 3'b011;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] ext_op;
      logic [1:0] npc_op;
      logic       alu_src;
      alu_op_e    alu_op;
      cmp_op_e    cmp_op;
      logic       mem_write;
      logic [2:0] data_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/exec_ctrl_mem_unit_alu.sv
// ALU plus compare unit. The compare always looks at rs/rt so branches work
// regardless of which operand B the ALU is using.
module exec_ctrl_mem_unit_alu
   import exec_ctrl_mem_unit_pkg::*;
(
   input  logic [2:0]  alu_op,
   input  logic [2:0]  cmp_op,
   input  logic        alu_src,
   input  logic [4:0]  shamt,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [31:0] ext_imm,
   output logic [31:0] alu_result,
   output logic        cmp_result
);

   logic [31:0] op_b;

   assign op_b = alu_src ? ext_imm : rt_data;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD:   alu_result = rs_data + op_b;
         ALU_SUB:   alu_result = rs_data - op_b;
         ALU_OR:    alu_result = rs_data | op_b;
         ALU_AND:   alu_result = rs_data & op_b;
         ALU_SLL:   alu_result = op_b << shamt;
         ALU_PASSB: alu_result = op_b;
         default:   alu_result = '0;
      endcase
   end

   always_comb begin
      cmp_result = 1'b0;
      case (cmp_op)
         CMP_EQ:  cmp_result = (rs_data == rt_data);
         CMP_NE:  cmp_result = (rs_data != rt_data);
         CMP_LT:  cmp_result = ($signed(rs_data) < $signed(rt_data));
         default: cmp_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_ctrl_mem_unit_decoder.sv
// Main controller: maps op/func to the full set of control fields.
// Unrecognised encodings decode to all-zero controls (a harmless no-op).
module exec_ctrl_mem_unit_decoder
   import exec_ctrl_mem_unit_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] ext_op,
   output logic [1:0] npc_op,
   output logic       alu_src,
   output logic [2:0] alu_op,
   output logic [2:0] cmp_op,
   output logic       mem_write,
   output logic [2:0] data_to_reg
);

   ctrl_t ctrl;

   always_comb begin
      ctrl = CTRL_NONE;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADDU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
               FN_SUBU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
               FN_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
               FN_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
               FN_SLL:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLL; end
               FN_SLT: begin
                  ctrl.reg_write   = 1'b1;
                  ctrl.cmp_op      = CMP_LT;
                  ctrl.data_to_reg = D2R_CMP;
               end
               FN_JR:   ctrl.npc_op = NPC_RS;
               default: ctrl = CTRL_NONE;
            endcase
         end
         OP_ORI: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = DST_RT;
            ctrl.ext_op    = EXT_ZERO;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OR;
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = DST_RT;
            ctrl.ext_op    = EXT_LUI;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_PASSB;
         end
         OP_LW: begin
            ctrl.reg_write   = 1'b1;
            ctrl.reg_dst     = DST_RT;
            ctrl.ext_op      = EXT_SIGN;
            ctrl.alu_src     = 1'b1;
            ctrl.alu_op      = ALU_ADD;
            ctrl.data_to_reg = D2R_MEM;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.ext_op    = EXT_SIGN;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_BEQ: begin ctrl.npc_op = NPC_BRANCH; ctrl.cmp_op = CMP_EQ; end
         OP_BNE: begin ctrl.npc_op = NPC_BRANCH; ctrl.cmp_op = CMP_NE; end
         OP_J:   ctrl.npc_op = NPC_JUMP;
         OP_JAL: begin
            ctrl.npc_op      = NPC_JUMP;
            ctrl.reg_write   = 1'b1;
            ctrl.reg_dst     = DST_RA;
            ctrl.data_to_reg = D2R_PC4;
         end
         default: ctrl = CTRL_NONE;
      endcase
   end

   assign reg_write   = ctrl.reg_write;
   assign reg_dst     = ctrl.reg_dst;
   assign ext_op      = ctrl.ext_op;
   assign npc_op      = ctrl.npc_op;
   assign alu_src     = ctrl.alu_src;
   assign alu_op      = ctrl.alu_op;
   assign cmp_op      = ctrl.cmp_op;
   assign mem_write   = ctrl.mem_write;
   assign data_to_reg = ctrl.data_to_reg;

endmodule

// File: rtl/exec_dm.sv
// Word-addressed data memory: combinational read, clocked write. Reset clears
// every word and takes priority over a simultaneous write.
module exec_dm #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] mem_reg [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (we) begin
         mem_reg[addr] <= wdata;
      end
   end

   assign rdata = mem_reg[addr];

endmodule

// File: rtl/exec_ctrl_mem_unit.sv
// Execute/memory slice of the single-cycle core: decoder, ALU/compare and
// data memory addressed by the word bits of the ALU result.
module exec_ctrl_mem_unit
   import exec_ctrl_mem_unit_pkg::*;
#(
   parameter int DM_ADDR_W = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [31:0] ext_imm,
   output logic [31:0] alu_result,
   output logic        cmp_result,
   output logic [31:0] mem_rdata,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  ext_op,
   output logic [1:0]  npc_op,
   output logic        mem_write,
   output logic [2:0]  data_to_reg
);

   logic       alu_src;
   logic [2:0] alu_op;
   logic [2:0] cmp_op;
   logic       unused_instr;

   // Register specifiers are consumed by the GRF, not by this slice.
   assign unused_instr = &{1'b0, instr[25:11]};

   exec_ctrl_mem_unit_decoder u_decoder (
      .op          (instr[31:26]),
      .func        (instr[5:0]),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .ext_op      (ext_op),
      .npc_op      (npc_op),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .cmp_op      (cmp_op),
      .mem_write   (mem_write),
      .data_to_reg (data_to_reg)
   );

   exec_ctrl_mem_unit_alu u_alu (
      .alu_op     (alu_op),
      .cmp_op     (cmp_op),
      .alu_src    (alu_src),
      .shamt      (instr[10:6]),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .ext_imm    (ext_imm),
      .alu_result (alu_result),
      .cmp_result (cmp_result)
   );

   exec_dm #(
      .ADDR_W (DM_ADDR_W)
   ) u_dm (
      .clk   (clk),
      .reset (reset),
      .we    (mem_write),
      .addr  (alu_result[DM_ADDR_W+1:2]),
      .wdata (rt_data),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
// Directed and randomized checks of the execute/memory slice against a
// mnemonic-level reference model with a sparse memory image.
module tb_exec_ctrl_mem_unit;

   typedef enum int {
      I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_JR, I_ORI, I_LUI,
      I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_BAD_OP, I_BAD_FN, I_NUM
   } ins_e;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, rs_data, rt_data, ext_imm;
   logic [31:0] alu_result, mem_rdata;
   logic        cmp_result, reg_write, mem_write;
   logic [1:0]  reg_dst, ext_op, npc_op;
   logic [2:0]  data_to_reg;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem_model [int];

   exec_ctrl_mem_unit dut (
      .clk(clk), .reset(reset), .instr(instr), .rs_data(rs_data),
      .rt_data(rt_data), .ext_imm(ext_imm), .alu_result(alu_result),
      .cmp_result(cmp_result), .mem_rdata(mem_rdata), .reg_write(reg_write),
      .reg_dst(reg_dst), .ext_op(ext_op), .npc_op(npc_op),
      .mem_write(mem_write), .data_to_reg(data_to_reg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Build an instruction word of the given kind with random don't-care fields.
   function automatic logic [31:0] enc(input ins_e k);
      logic [31:0] w;
      w = $urandom;
      case (k)
         I_ADDU:   w = {6'b0, w[25:6], 6'b100001};
         I_SUBU:   w = {6'b0, w[25:6], 6'b100011};
         I_AND:    w = {6'b0, w[25:6], 6'b100100};
         I_OR:     w = {6'b0, w[25:6], 6'b100101};
         I_SLT:    w = {6'b0, w[25:6], 6'b101010};
         I_SLL:    w = {6'b0, w[25:6], 6'b000000};
         I_JR:     w = {6'b0, w[25:6], 6'b001000};
         I_BAD_FN: w = {6'b0, w[25:6], w[31] ? 6'b111111 : 6'b100000};
         I_ORI:    w[31:26] = 6'b001101;
         I_LUI:    w[31:26] = 6'b001111;
         I_LW:     w[31:26] = 6'b100011;
         I_SW:     w[31:26] = 6'b101011;
         I_BEQ:    w[31:26] = 6'b000100;
         I_BNE:    w[31:26] = 6'b000101;
         I_J:      w[31:26] = 6'b000010;
         I_JAL:    w[31:26] = 6'b000011;
         default:  w[31:26] = w[0] ? 6'b111111 : 6'b100000;
      endcase
      return w;
   endfunction

   function automatic ins_e classify(input logic [31:0] w);
      if (w[31:26] == 6'd0) begin
         case (w[5:0])
            6'b100001: return I_ADDU;
            6'b100011: return I_SUBU;
            6'b100100: return I_AND;
            6'b100101: return I_OR;
            6'b101010: return I_SLT;
            6'b000000: return I_SLL;
            6'b001000: return I_JR;
            default:   return I_BAD_FN;
         endcase
      end
      case (w[31:26])
         6'b001101: return I_ORI;
         6'b001111: return I_LUI;
         6'b100011: return I_LW;
         6'b101011: return I_SW;
         6'b000100: return I_BEQ;
         6'b000101: return I_BNE;
         6'b000010: return I_J;
         6'b000011: return I_JAL;
         default:   return I_BAD_OP;
      endcase
   endfunction

   // Reference model: check every output, then advance one clock and apply
   // the memory effect of the instruction (or the reset clear).
   task automatic step(input string tag);
      ins_e        k;
      logic [31:0] e_alu, e_rd;
      logic        e_cmp, e_rw, e_mw;
      logic [1:0]  e_dst, e_ext, e_npc;
      logic [2:0]  e_d2r;
      int          idx;
      k     = classify(instr);
      e_rw  = k inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_ORI, I_LUI, I_LW, I_JAL};
      e_mw  = (k == I_SW);
      e_dst = (k inside {I_ORI, I_LUI, I_LW}) ? 2'd1 : (k == I_JAL) ? 2'd2 : 2'd0;
      e_ext = (k == I_LUI) ? 2'd2 : (k inside {I_LW, I_SW}) ? 2'd1 : 2'd0;
      e_npc = (k == I_JR) ? 2'd3 : (k inside {I_BEQ, I_BNE}) ? 2'd1 :
              (k inside {I_J, I_JAL}) ? 2'd2 : 2'd0;
      e_d2r = (k == I_LW) ? 3'd1 : (k == I_JAL) ? 3'd2 : (k == I_SLT) ? 3'd3 : 3'd0;
      case (k)
         I_SUBU:       e_alu = rs_data - rt_data;
         I_AND:        e_alu = rs_data & rt_data;
         I_OR:         e_alu = rs_data | rt_data;
         I_SLL:        e_alu = rt_data << instr[10:6];
         I_ORI:        e_alu = rs_data | ext_imm;
         I_LUI:        e_alu = ext_imm;
         I_LW, I_SW:   e_alu = rs_data + ext_imm;
         default:      e_alu = rs_data + rt_data;
      endcase
      if (k == I_BNE)      e_cmp = (rs_data != rt_data);
      else if (k == I_SLT) e_cmp = ($signed(rs_data) < $signed(rt_data));
      else                 e_cmp = (rs_data == rt_data);
      idx  = int'(e_alu[13:2]);
      e_rd = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
      #2;
      chk({tag, ".alu_result"},  alu_result, e_alu);
      chk({tag, ".cmp_result"},  {31'b0, cmp_result}, {31'b0, e_cmp});
      chk({tag, ".mem_rdata"},   mem_rdata, e_rd);
      chk({tag, ".ctrl"},
          {20'b0, reg_write, reg_dst, ext_op, npc_op, mem_write, data_to_reg},
          {20'b0, e_rw, e_dst, e_ext, e_npc, e_mw, e_d2r});
      @(posedge clk);
      #1;
      if (reset)     mem_model.delete();
      else if (e_mw) mem_model[idx] = rt_data;
   endtask

   task automatic drive(input ins_e k, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm);
      instr = enc(k); rs_data = rs; rt_data = rt; ext_imm = imm;
   endtask

   initial begin
      ins_e k;
      reset = 1'b1;
      drive(I_BAD_OP, 0, 0, 0);
      @(posedge clk); #1;
      mem_model.delete();
      step("reset");
      reset = 1'b0;

      drive(I_LW, 32'h0, 32'h0, 32'h100);
      #2; chk("post_reset_rdata", mem_rdata, 32'h0);
      step("lw_after_reset");

      drive(I_ADDU, 32'h7FFFFFFF, 32'h1, 32'h0);
      #2; chk("addu_wrap", alu_result, 32'h80000000);
      step("addu");
      drive(I_ORI, 32'h12340000, 32'h0, 32'h0000FFFF);
      #2; chk("ori_value", alu_result, 32'h1234FFFF);
      step("ori");
      drive(I_LUI, 32'h5555AAAA, 32'h0, 32'hABCD0000);
      #2; chk("lui_value", alu_result, 32'hABCD0000);
      step("lui");

      drive(I_SW, 32'h0, 32'hDEADBEEF, 32'h8);
      step("sw_8");
      drive(I_LW, 32'h0, 32'h0, 32'h8);
      #2; chk("lw_8_data", mem_rdata, 32'hDEADBEEF);
      step("lw_8");
      drive(I_LW, 32'h0, 32'h0, 32'hB);
      #2; chk("lw_b_same_word", mem_rdata, 32'hDEADBEEF);
      step("lw_b");

      drive(I_BEQ, 32'd5, 32'd5, 32'h0);   step("beq_eq");
      drive(I_BNE, 32'd5, 32'd5, 32'h0);   step("bne_eq");
      drive(I_SLT, 32'hFFFFFFFF, 32'd1, 0); step("slt_neg");
      drive(I_JAL, 32'h0, 32'h0, 32'h0);   step("jal");
      drive(I_JR, 32'h00400000, 32'h0, 0); step("jr");
      drive(I_BAD_OP, 32'h1, 32'h2, 32'h3); instr[31:26] = 6'b111111;
      step("op_3f");

      instr = enc(I_SLL); instr[10:6] = 5'd31; rs_data = 32'hFFFF0000;
      rt_data = 32'h1; ext_imm = 32'h0;
      #2; chk("sll_31", alu_result, 32'h80000000);
      step("sll");

      drive(I_SW, 32'h0, 32'h1, 32'hC);   step("sw_word3");
      drive(I_SW, 32'h0, 32'h55, 32'hC);
      reset = 1'b1;                        step("reset_vs_write");
      reset = 1'b0;
      drive(I_LW, 32'h0, 32'h0, 32'hC);
      #2; chk("word3_cleared", mem_rdata, 32'h0);
      step("lw_word3");

      for (int i = 0; i < 400; i++) begin
         k = ins_e'($urandom_range(0, int'(I_NUM) - 1));
         drive(k, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) rt_data = rs_data;
         if (k == I_LW || k == I_SW) begin
            rs_data = $urandom_range(0, 63);
            ext_imm = ($urandom & 32'hFFFFC000) | 32'($urandom_range(0, 3));
         end
         reset = ($urandom_range(0, 59) == 0);
         step("rand");
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
